// File: rtl/shape_drawer_if.sv
// Box-draw handshake between the display FSM (master) and the shape drawer
// (slave), together with the pixel-write signals that go on to the VGA adapter.
interface shape_drawer_if #(
  parameter int COLOUR_W = 3
);
  logic                loadStartAddress;
  logic                startingAddressLoaded;
  logic [7:0]          startX;
  logic [7:0]          startY;
  logic [COLOUR_W-1:0] colourIn;
  logic [7:0]          x;
  logic [7:0]          y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                shapeDone;

  // Display FSM side: presents the origin/colour and starts a box.
  modport master (
    output loadStartAddress, startingAddressLoaded, startX, startY, colourIn,
    input  x, y, colour, plot, busy, shapeDone
  );

  // Drawer side: consumes the request and produces the pixel stream.
  modport slave (
    input  loadStartAddress, startingAddressLoaded, startX, startY, colourIn,
    output x, y, colour, plot, busy, shapeDone
  );
endinterface

// File: rtl/shape_drawer.sv
// Shape drawer: latches a box origin and colour, then emits a solid
// BOX_W x BOX_H rectangle one pixel per clock in raster order. Pixels that
// fall off the SCREEN_W x SCREEN_H grid still take their cycle but are not
// plotted, so the box always takes the same number of cycles. shapeDone
// pulses for one cycle after the last pixel.
module shape_drawer #(
  parameter int BOX_W    = 16,
  parameter int BOX_H    = 8,
  parameter int SCREEN_W = 240,
  parameter int SCREEN_H = 180,
  parameter int COLOUR_W = 3
) (
  input  logic          clock,
  input  logic          resetn,
  shape_drawer_if.slave bus
);

  localparam int CXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int CYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [7:0]          ox_q;
  logic [7:0]          oy_q;
  logic [COLOUR_W-1:0] col_q;
  logic [CXW-1:0]      cx_q;
  logic [CYW-1:0]      cy_q;
  logic [CXW-1:0]      cx_d;
  logic [CYW-1:0]      cy_d;
  logic [7:0]          x_q;
  logic [7:0]          y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                plot_q;
  logic                done_q;

  logic [8:0]          sumX;
  logic [8:0]          sumY;
  logic                onScreen;
  logic                lastX;
  logic                lastY;

  // Pixel address for the current scan position, its clip test and the raster-order counter advance.
  always_comb begin
    sumX     = 9'(ox_q) + 9'(cx_q);
    sumY     = 9'(oy_q) + 9'(cy_q);
    onScreen = (sumX < 9'(SCREEN_W)) && (sumY < 9'(SCREEN_H));
    lastX    = (cx_q == CXW'(BOX_W - 1));
    lastY    = (cy_q == CYW'(BOX_H - 1));
    cx_d     = lastX ? '0 : cx_q + CXW'(1);
    cy_d     = lastX ? cy_q + CYW'(1) : cy_q;
  end

  // Control FSM with registered pixel outputs; the origin only loads while idle so it never moves mid-box.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      ox_q     <= '0;
      oy_q     <= '0;
      col_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.loadStartAddress) begin
            ox_q  <= bus.startX;
            oy_q  <= bus.startY;
            col_q <= bus.colourIn;
          end
          if (bus.startingAddressLoaded) begin
            state_q <= S_DRAW;
            cx_q    <= '0;
            cy_q    <= '0;
          end
        end
        S_DRAW: begin
          x_q      <= sumX[7:0];
          y_q      <= sumY[7:0];
          colour_q <= col_q;
          plot_q   <= onScreen;
          cx_q     <= cx_d;
          cy_q     <= cy_d;
          if (lastX && lastY) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          plot_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.colour    = colour_q;
  assign bus.plot      = plot_q;
  assign bus.shapeDone = done_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_shape_drawer.sv
// Testbench for shape_drawer: directed handshake scenarios followed by random
// boxes, every cycle compared against a pixel-list model of the box.
module tb_shape_drawer;

  localparam int BOX_W    = 16;
  localparam int BOX_H    = 8;
  localparam int SCREEN_W = 240;
  localparam int SCREEN_H = 180;
  localparam int COLOUR_W = 3;
  localparam int NPIX     = BOX_W * BOX_H;

  logic clock = 1'b0;
  logic resetn;

  shape_drawer_if #(.COLOUR_W(COLOUR_W)) bus ();

  shape_drawer #(
    .BOX_W   (BOX_W),
    .BOX_H   (BOX_H),
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H),
    .COLOUR_W(COLOUR_W)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Latched origin/colour as the display FSM believes it to be.
  int modelX = 0;
  int modelY = 0;
  int modelC = 0;

  int lastX = 0;
  int lastY = 0;
  int lastC = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit load, input bit start, input int sx, input int sy, input int col);
    bus.loadStartAddress      = load;
    bus.startingAddressLoaded = start;
    bus.startX                = 8'(sx);
    bus.startY                = 8'(sy);
    bus.colourIn              = COLOUR_W'(col);
  endtask

  task automatic idleNoise();
    applyStimulus(1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 7)));
  endtask

  // Expected pixel k of a box at the model origin: raster scan, 9-bit sums, clip against the grid.
  task automatic checkPixel(input int k, output bit expPlot);
    int px;
    int py;
    px      = modelX + (k % BOX_W);
    py      = modelY + (k / BOX_W);
    expPlot = (px < SCREEN_W) && (py < SCREEN_H);
    checkOutput($sformatf("px%0d.plot", k), bus.plot, expPlot);
    checkOutput($sformatf("px%0d.x", k), bus.x, px % 256);
    checkOutput($sformatf("px%0d.y", k), bus.y, py % 256);
    checkOutput($sformatf("px%0d.colour", k), bus.colour, modelC);
    checkOutput($sformatf("px%0d.busy", k), bus.busy, 1);
    checkOutput($sformatf("px%0d.shapeDone", k), bus.shapeDone, 0);
    lastX = px % 256;
    lastY = py % 256;
    lastC = modelC;
  endtask

  // One full box as the display FSM does it; called and returns on a falling edge.
  // injectAt >= 0 drives a load (startX=99) and start while the box is in progress.
  task automatic runBox(input bit doLoad, input bit sameCycle, input int sx, input int sy,
                        input int col, input int injectAt, output int plotsSeen, output int plotsExp);
    bit expPlot;
    plotsSeen = 0;
    plotsExp  = 0;
    if (doLoad && !sameCycle) begin
      applyStimulus(1'b1, 1'b0, sx, sy, col);
      @(posedge clock);
      @(negedge clock);
      modelX = sx;
      modelY = sy;
      modelC = col;
      checkOutput("loadIdle.plot", bus.plot, 0);
      checkOutput("loadIdle.busy", bus.busy, 0);
    end
    if (doLoad && sameCycle) begin
      applyStimulus(1'b1, 1'b1, sx, sy, col);
      modelX = sx;
      modelY = sy;
      modelC = col;
    end else begin
      applyStimulus(1'b0, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 7)));
    end
    @(posedge clock);
    @(negedge clock);
    idleNoise();
    checkOutput("startEdge.plot", bus.plot, 0);
    checkOutput("startEdge.busy", bus.busy, 1);
    for (int k = 0; k < NPIX; k++) begin
      @(negedge clock);
      checkPixel(k, expPlot);
      if (expPlot) plotsExp++;
      if (bus.plot === 1'b1) plotsSeen++;
      if (k == injectAt) begin
        applyStimulus(1'b1, 1'b1, 99, int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
      end else begin
        idleNoise();
      end
    end
    @(negedge clock);
    idleNoise();
    checkOutput("done.shapeDone", bus.shapeDone, 1);
    checkOutput("done.plot", bus.plot, 0);
    checkOutput("done.busy", bus.busy, 0);
    checkOutput("done.xHold", bus.x, lastX);
    checkOutput("done.yHold", bus.y, lastY);
    checkOutput("done.colourHold", bus.colour, lastC);
    checkOutput("box.plotCount", plotsSeen, plotsExp);
  endtask

  // Start a box from the current origin and pull reset after pixel abortAt.
  task automatic runAbort(input int abortAt);
    bit expPlot;
    applyStimulus(1'b0, 1'b1, 0, 0, 0);
    @(posedge clock);
    @(negedge clock);
    idleNoise();
    for (int k = 0; k <= abortAt; k++) begin
      @(negedge clock);
      checkPixel(k, expPlot);
    end
    resetn = 1'b0;
    #1;
    checkOutput("abort.plot", bus.plot, 0);
    checkOutput("abort.busy", bus.busy, 0);
    checkOutput("abort.shapeDone", bus.shapeDone, 0);
    checkOutput("abort.x", bus.x, 0);
    checkOutput("abort.y", bus.y, 0);
    checkOutput("abort.colour", bus.colour, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("abortHold.shapeDone", bus.shapeDone, 0);
      checkOutput("abortHold.plot", bus.plot, 0);
    end
    resetn = 1'b1;
    modelX = 0;
    modelY = 0;
    modelC = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checkOutput("postAbort.shapeDone", bus.shapeDone, 0);
      checkOutput("postAbort.busy", bus.busy, 0);
    end
  endtask

  int seen;
  int expd;
  int sumSeen;
  int sumExp;

  initial begin
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clock);
    checkOutput("reset.plot", bus.plot, 0);
    checkOutput("reset.busy", bus.busy, 0);
    checkOutput("reset.shapeDone", bus.shapeDone, 0);
    checkOutput("reset.x", bus.x, 0);
    checkOutput("reset.y", bus.y, 0);
    checkOutput("reset.colour", bus.colour, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("idle.plot", bus.plot, 0);

    $display("[TB] basic box at (10,20)");
    runBox(1'b1, 1'b0, 10, 20, 3'b100, -1, seen, expd);
    checkOutput("basic.plots", seen, 128);

    $display("[TB] clipped box at (232,176)");
    runBox(1'b1, 1'b0, 232, 176, 3'b001, -1, seen, expd);
    checkOutput("clip.plots", seen, 32);

    $display("[TB] three back-to-back boxes");
    sumSeen = 0;
    sumExp  = 0;
    for (int b = 0; b < 3; b++) begin
      runBox(1'b1, 1'b0, int'($urandom_range(0, 200)), int'($urandom_range(0, 150)),
             int'($urandom_range(0, 7)), -1, seen, expd);
      sumSeen += seen;
      sumExp  += expd;
    end
    checkOutput("b2b.plots", sumSeen, 384);

    $display("[TB] load ignored while drawing");
    runBox(1'b1, 1'b0, 50, 60, 3'b010, 40, seen, expd);
    runBox(1'b0, 1'b0, 0, 0, 0, 127, seen, expd);
    checkOutput("oldOrigin.x", modelX, 50);

    $display("[TB] reset mid-draw");
    runAbort(60);
    runBox(1'b0, 1'b0, 0, 0, 0, -1, seen, expd);

    $display("[TB] load and start together");
    runBox(1'b1, 1'b1, 0, 0, 3'b111, -1, seen, expd);

    $display("[TB] random boxes");
    for (int r = 0; r < 10; r++) begin
      int sx;
      int sy;
      int gap;
      sx  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(220, 255)) : int'($urandom_range(0, 255));
      sy  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(165, 255)) : int'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        checkOutput("gap.plot", bus.plot, 0);
      end
      runBox(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), sx, sy,
             int'($urandom_range(0, 7)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NPIX - 1)) : -1, seen, expd);
    end

    @(negedge clock);
    checkOutput("final.shapeDone", bus.shapeDone, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
